bip8_check_multi: RTL and testbench
===================================

Name: bip8_check_multi

Overview:
- Parametrised B1 (BIP-8) checker for the SDH receive path. It sits after the framer/descrambler.
- Accepts LANES bytes per clock and computes even BIP-8 over each frame.
- Compares each frame's result with the B1 byte extracted from the following frame.
- Reports per-frame error flag and errored-bit count, a saturating error counter, and a windowed excessive-error alarm.

Parameters:
- LANES, 1, bytes per rx_data word (1, 2, 4, 8 allowed).
- CNT_W, 16, width of the accumulated error counter.
- WIN_FRAMES, 8000, frames per alarm evaluation window (>=1).
- EXC_THRESH, 1000, errors per window at or above which exc_alarm asserts.

Ports:
- sdh_clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- rx_valid  in  1  rx_data qualifies this cycle.
- rx_frame_start  in  1  current valid word is the first word of a frame; only meaningful with rx_valid.
- rx_data  in  8*LANES  received data; lane 0 = bits [7:0] = earliest byte.
- rec_b1_valid  in  1  rec_b1 holds B1 extracted from the current frame.
- rec_b1  in  8  received B1 byte.
- cnt_clr  in  1  clears bip_err_cnt.
- bip_cal  out  8  BIP-8 of the last completed frame.
- bip_cal_valid  out  1  bip_cal holds a completed frame.
- b1_err  out  1  one-cycle pulse, mismatch detected.
- b1_err_bits  out  4  number of mismatched bits, 0..8; valid with b1_chk_done.
- b1_chk_done  out  1  one-cycle pulse, a comparison occurred.
- bip_err_cnt  out  CNT_W  saturating accumulated error count.
- exc_alarm  out  1  excessive-error alarm, level.

Behaviour:
- Reset: all outputs, the accumulator, counters and FSM are cleared to 0 / IDLE.
- Lane fold: word_xor = XOR of all LANES bytes of rx_data.
- Accumulation (rx_valid=1):
  - If rx_frame_start: acc <= word_xor, and bip_cal <= acc.
  - Else: acc <= acc ^ word_xor.
  - rx_valid=0: acc holds.
- FSM:
  - IDLE: on rx_valid & rx_frame_start -> ACQ. No bip_cal update from IDLE.
  - ACQ: on next frame start -> RUN; bip_cal loaded; bip_cal_valid <= 1.
  - RUN: on frame start, bip_cal reloads. Stays in RUN until rst.
- Compare:
  - Occurs when rec_b1_valid & bip_cal_valid. Registered, one cycle latency.
  - Outputs: b1_chk_done=1; b1_err_bits=popcount(rec_b1^bip_cal); b1_err=(b1_err_bits!=0).
  - rec_b1_valid while bip_cal_valid=0 is ignored: no done pulse, no count.
- Simultaneous rec_b1_valid and a bip_cal reload in the same cycle: the compare uses the pre-update bip_cal.
- Error counter:
  - On b1_chk_done, bip_err_cnt += increment (bit count or block, see Optional Feature), saturating at 2^CNT_W-1.
  - cnt_clr takes priority over an increment in the same cycle; the value becomes 0, and that cycle's increment is dropped.
- Window:
  - frame counter counts bip_cal reloads in RUN, 0..WIN_FRAMES-1.
  - win_err accumulates the same increments and saturates at EXC_THRESH.
  - Window end is the reload when the frame counter = WIN_FRAMES-1. At window end, exc_alarm <= (win_err + same-cycle increment >= EXC_THRESH), then win_err and the frame counter clear.
  - exc_alarm changes only at window end.
- Reset mid-frame returns the block to IDLE. One full frame is discarded before checking resumes.

Optional Feature:
- Macro B1_BLOCK_COUNT_EN.
- Defined: each errored frame increments bip_err_cnt and win_err by 1 (block error count, G.826 style).
- Undefined: the increment is b1_err_bits, 0..8 (bit error count).
- b1_err and b1_err_bits behave identically in both builds.

Decomposition:
- Package sdh_bip_pkg:
  - BIP_W=8, LANE_W=8.
  - FSM state enum {IDLE, ACQ, RUN}.
  - popcount8 function.
- Sub-module bip_lane_fold: combinational LANES-byte XOR reduction, reused by the B2/B3 checkers.

Test Plan:
- LANES=1, frame bytes 0x01,0x02,0x04, next frame start, rec_b1=0x07 -> bip_cal=0x07, b1_chk_done pulse, b1_err=0, b1_err_bits=0.
- Same frame, rec_b1=0x06 -> b1_err=1, b1_err_bits=1, bip_err_cnt=1. Repeat with rec_b1=0xF8 -> bits 8, cnt=9; with B1_BLOCK_COUNT_EN, cnt=2.
- LANES=4, word 0x04030201 then a frame start -> bip_cal=0x04^0x03^0x02^0x01=0x04. rec_b1_valid before the first completed frame -> no b1_chk_done.
- CNT_W=4, 3 frames each with 8 bit errors -> cnt 8, then 15 (saturated), then 15. Asserting cnt_clr in the same cycle as a check -> 0.
- WIN_FRAMES=4, EXC_THRESH=3, 3 single-bit errors in window -> exc_alarm=1 at the 4th reload. Following clean window -> exc_alarm=0.
- Assert rst mid-frame in RUN -> all outputs 0. The first post-reset frame gives no check; checking resumes on the second frame.

Source files
------------

// File: rtl/sdh_bip_pkg.sv
// Shared types and helpers for the SDH B1/B2/B3 parity checkers.
package sdh_bip_pkg;
  localparam int BIP_W  = 8;
  localparam int LANE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    RUN  = 2'd2
  } bip_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/bip_lane_fold.sv
// XOR-reduces LANES bytes of a data word down to one byte of running parity.
module bip_lane_fold
  import sdh_bip_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic [LANE_W*LANES-1:0] data_i,
  output logic [LANE_W-1:0]       xor_o
);
  logic [LANES:0][LANE_W-1:0] part;

  assign part[0] = '0;
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign part[g+1] = part[g] ^ data_i[g*LANE_W +: LANE_W];
  end
  assign xor_o = part[LANES];
endmodule

// File: rtl/bip8_check_multi.sv
// B1 (BIP-8) checker: per-frame parity, compare against next frame's B1, error counting and windowed alarm.
// Define B1_BLOCK_COUNT_EN to count errored frames (block errors) instead of errored bits.
module bip8_check_multi
  import sdh_bip_pkg::*;
#(
  parameter int LANES      = 1,
  parameter int CNT_W      = 16,
  parameter int WIN_FRAMES = 8000,
  parameter int EXC_THRESH = 1000
) (
  input  logic               sdh_clk,
  input  logic               rst,
  input  logic               rx_valid,
  input  logic               rx_frame_start,
  input  logic [8*LANES-1:0] rx_data,
  input  logic               rec_b1_valid,
  input  logic [7:0]         rec_b1,
  input  logic               cnt_clr,
  output logic [7:0]         bip_cal,
  output logic               bip_cal_valid,
  output logic               b1_err,
  output logic [3:0]         b1_err_bits,
  output logic               b1_chk_done,
  output logic [CNT_W-1:0]   bip_err_cnt,
  output logic               exc_alarm
);
  localparam int FW = (WIN_FRAMES > 1) ? $clog2(WIN_FRAMES) : 1;
  localparam int WW = $clog2(EXC_THRESH + 9) + 1;
  localparam logic [FW-1:0] FRM_LAST = FW'(WIN_FRAMES - 1);
  localparam logic [WW-1:0] THR      = WW'(EXC_THRESH);

  bip_state_e       state_q, state_d;
  logic [BIP_W-1:0] word_xor, acc_q, cal_q;
  logic             cal_vld_q, done_q, err_q, alarm_q, alarm_d;
  logic [3:0]       bits_q, diff_bits, inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_sum;
  logic [FW-1:0]    frm_q, frm_d;
  logic [WW-1:0]    werr_q, werr_d, werr_sum;
  logic             sof, reload, reload_run, chk;

  bip_lane_fold #(.LANES(LANES)) u_fold (
    .data_i (rx_data),
    .xor_o  (word_xor)
  );

  assign sof        = rx_valid & rx_frame_start;
  assign reload     = sof & (state_q != IDLE);
  assign reload_run = sof & (state_q == RUN);
  // Compare against the registered bip_cal, so a same-cycle reload never leaks in.
  assign chk        = rec_b1_valid & cal_vld_q;
  assign diff_bits  = popcount8(rec_b1 ^ cal_q);

`ifdef B1_BLOCK_COUNT_EN
  assign inc = {3'b000, done_q & err_q};
`else
  assign inc = done_q ? bits_q : 4'd0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sof) state_d = ACQ;
      ACQ:     if (sof) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_sum  = {1'b0, cnt_q} + (CNT_W+1)'(inc);
    cnt_d    = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    if (cnt_clr) cnt_d = '0;
    werr_sum = werr_q + WW'(inc);
    werr_d   = (werr_sum >= THR) ? THR : werr_sum;
    frm_d    = frm_q;
    alarm_d  = alarm_q;
    if (reload_run) begin
      if (frm_q == FRM_LAST) begin
        alarm_d = (werr_sum >= THR);
        werr_d  = '0;
        frm_d   = '0;
      end else begin
        frm_d = frm_q + FW'(1);
      end
    end
  end

  always_ff @(posedge sdh_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cal_q     <= '0;
      cal_vld_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      bits_q    <= '0;
      cnt_q     <= '0;
      frm_q     <= '0;
      werr_q    <= '0;
      alarm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (rx_valid) acc_q <= rx_frame_start ? word_xor : (acc_q ^ word_xor);
      if (reload) begin
        cal_q     <= acc_q;
        cal_vld_q <= 1'b1;
      end
      done_q <= chk;
      err_q  <= chk & (diff_bits != 4'd0);
      if (chk) bits_q <= diff_bits;
      cnt_q   <= cnt_d;
      frm_q   <= frm_d;
      werr_q  <= werr_d;
      alarm_q <= alarm_d;
    end
  end

  assign bip_cal       = cal_q;
  assign bip_cal_valid = cal_vld_q;
  assign b1_err        = err_q;
  assign b1_err_bits   = bits_q;
  assign b1_chk_done   = done_q;
  assign bip_err_cnt   = cnt_q;
  assign exc_alarm     = alarm_q;
endmodule

// File: tb/tb_bip8_check_multi.sv
// Directed bench for bip8_check_multi: a LANES=1 small-window instance and a LANES=4 instance, checked against a frame-level model.
module tb_bip8_check_multi;
`ifdef B1_BLOCK_COUNT_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, go;
  int   n_chk, n_fail;

  logic       a_v, a_fs, a_b1v, a_clr;
  logic [7:0] a_d, a_b1, a_cal;
  logic       a_calv, a_err, a_done, a_alarm;
  logic [3:0] a_bits, a_cnt;

  logic        b_v, b_fs, b_b1v, b_clr;
  logic [31:0] b_d;
  logic [7:0]  b_b1, b_cal;
  logic        b_calv, b_err, b_done, b_alarm;
  logic [3:0]  b_bits;
  logic [15:0] b_cnt;

  bip8_check_multi #(.LANES(1), .CNT_W(4), .WIN_FRAMES(4), .EXC_THRESH(3)) dut_a (
    .sdh_clk(clk), .rst(rst), .rx_valid(a_v), .rx_frame_start(a_fs), .rx_data(a_d),
    .rec_b1_valid(a_b1v), .rec_b1(a_b1), .cnt_clr(a_clr), .bip_cal(a_cal),
    .bip_cal_valid(a_calv), .b1_err(a_err), .b1_err_bits(a_bits), .b1_chk_done(a_done),
    .bip_err_cnt(a_cnt), .exc_alarm(a_alarm));

  bip8_check_multi #(.LANES(4)) dut_b (
    .sdh_clk(clk), .rst(rst), .rx_valid(b_v), .rx_frame_start(b_fs), .rx_data(b_d),
    .rec_b1_valid(b_b1v), .rec_b1(b_b1), .cnt_clr(b_clr), .bip_cal(b_cal),
    .bip_cal_valid(b_calv), .b1_err(b_err), .b1_err_bits(b_bits), .b1_chk_done(b_done),
    .bip_err_cnt(b_cnt), .exc_alarm(b_alarm));

  // Frame-level model: index 0 = dut_a, 1 = dut_b
  int m_starts[2], m_par[2], m_last[2], m_have[2], m_done[2], m_bits[2];
  int m_cnt[2], m_frames[2], m_werr[2], m_alarm[2];

  function automatic void mstep(int k, bit r, bit v, bit fs, logic [63:0] d, int nb,
                                bit b1v, logic [7:0] b1, bit clr);
    int cmax, win, thr, inc, fold, bits;
    bit nd;
    cmax = (k == 0) ? 15 : 65535;
    win  = (k == 0) ? 4 : 8000;
    thr  = (k == 0) ? 3 : 1000;
    if (r) begin
      m_starts[k] = 0; m_par[k] = 0; m_last[k] = 0; m_have[k] = 0; m_done[k] = 0;
      m_bits[k] = 0; m_cnt[k] = 0; m_frames[k] = 0; m_werr[k] = 0; m_alarm[k] = 0;
      return;
    end
    inc = 0;
    if (m_done[k] != 0) inc = BLK ? ((m_bits[k] != 0) ? 1 : 0) : m_bits[k];
    nd   = b1v && (m_have[k] != 0);
    bits = $countones(b1 ^ 8'(m_last[k]));
    m_cnt[k] = clr ? 0 : ((m_cnt[k] + inc > cmax) ? cmax : m_cnt[k] + inc);
    if (v && fs && m_starts[k] >= 2 && m_frames[k] == win - 1) begin
      m_alarm[k]  = (m_werr[k] + inc >= thr) ? 1 : 0;
      m_werr[k]   = 0;
      m_frames[k] = 0;
    end else begin
      m_werr[k] = (m_werr[k] + inc > thr) ? thr : m_werr[k] + inc;
      if (v && fs && m_starts[k] >= 2) m_frames[k]++;
    end
    fold = 0;
    for (int i = 0; i < nb; i++) fold = fold ^ int'(d[8*i +: 8]);
    if (v) begin
      if (fs) begin
        if (m_starts[k] >= 1) begin m_last[k] = m_par[k]; m_have[k] = 1; end
        if (m_starts[k] < 3) m_starts[k]++;
        m_par[k] = fold;
      end else begin
        m_par[k] = m_par[k] ^ fold;
      end
    end
    m_done[k] = nd ? 1 : 0;
    m_bits[k] = nd ? bits : m_bits[k];
  endfunction

  always @(posedge clk) begin
    mstep(0, rst, a_v, a_fs, {56'b0, a_d}, 1, a_b1v, a_b1, a_clr);
    mstep(1, rst, b_v, b_fs, {32'b0, b_d}, 4, b_b1v, b_b1, b_clr);
  end

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input string p, input logic [7:0] cal, input logic calv,
                     input logic done, input logic err, input logic [3:0] bits,
                     input logic [31:0] cnt, input logic alarm);
    chk({p, ".bip_cal"}, {24'b0, cal}, m_last[k]);
    chk({p, ".bip_cal_valid"}, {31'b0, calv}, m_have[k]);
    chk({p, ".b1_chk_done"}, {31'b0, done}, m_done[k]);
    chk({p, ".b1_err"}, {31'b0, err}, (m_done[k] != 0 && m_bits[k] != 0) ? 1 : 0);
    if (m_done[k] != 0) chk({p, ".b1_err_bits"}, {28'b0, bits}, m_bits[k]);
    chk({p, ".bip_err_cnt"}, cnt, m_cnt[k]);
    chk({p, ".exc_alarm"}, {31'b0, alarm}, m_alarm[k]);
  endtask

  always @(negedge clk) if (go) begin
    cmp(0, "A", a_cal, a_calv, a_done, a_err, a_bits, {28'b0, a_cnt}, a_alarm);
    cmp(1, "B", b_cal, b_calv, b_done, b_err, b_bits, {16'b0, b_cnt}, b_alarm);
  end

  task automatic a_cyc(input bit v, fs, input logic [7:0] d, input bit b1v,
                       input logic [7:0] b1, input bit clr);
    a_v = v; a_fs = fs; a_d = d; a_b1v = b1v; a_b1 = b1; a_clr = clr;
    @(posedge clk); @(negedge clk);
    a_v = 1'b0; a_fs = 1'b0; a_b1v = 1'b0; a_clr = 1'b0;
  endtask

  task automatic b_cyc(input bit v, fs, input logic [31:0] d, input bit b1v,
                       input logic [7:0] b1);
    b_v = v; b_fs = fs; b_d = d; b_b1v = b1v; b_b1 = b1;
    @(posedge clk); @(negedge clk);
    b_v = 1'b0; b_fs = 1'b0; b_b1v = 1'b0;
  endtask

  task automatic a_frame(input logic [7:0] d0, d1, input bit c, input logic [7:0] b1);
    a_cyc(1, 1, d0, 0, 8'h00, 0);
    a_cyc(1, 0, d1, c, b1, 0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; go = 1'b0; rst = 1'b1;
    a_v = 0; a_fs = 0; a_d = 0; a_b1v = 0; a_b1 = 0; a_clr = 0;
    b_v = 0; b_fs = 0; b_d = 0; b_b1v = 0; b_b1 = 0; b_clr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    go = 1'b1;
    chk("rst.A.bip_cal", {24'b0, a_cal}, 0);
    chk("rst.A.bip_cal_valid", {31'b0, a_calv}, 0);
    chk("rst.A.bip_err_cnt", {28'b0, a_cnt}, 0);
    chk("rst.B.exc_alarm", {31'b0, b_alarm}, 0);
    rst = 1'b0;

    // LANES=4 fold, early rec_b1 ignored
    b_cyc(1, 1, 32'h04030201, 1, 8'h04);
    chk("B.early_done", {31'b0, b_done}, 0);
    b_cyc(1, 1, 32'hFF00FF00, 0, 8'h00);
    chk("B.fold_cal", {24'b0, b_cal}, 8'h04);
    chk("B.cal_valid", {31'b0, b_calv}, 1);
    b_cyc(1, 0, 32'h12345678, 1, 8'h04);
    chk("B.clean_done", {31'b0, b_done}, 1);
    b_cyc(1, 1, 32'h00000000, 0, 8'h00);
    chk("B.fold_cal2", {24'b0, b_cal}, 8'h08);
    b_cyc(1, 0, 32'h00000000, 1, 8'h09);
    chk("B.err_bits", {28'b0, b_bits}, 1);
    b_cyc(0, 0, 32'h0, 0, 8'h00);
    chk("B.cnt", {16'b0, b_cnt}, 1);

    // LANES=1 basic frame, with a hold cycle
    a_cyc(1, 1, 8'h01, 0, 8'h00, 0);
    a_cyc(1, 0, 8'h02, 0, 8'h00, 0);
    a_cyc(0, 0, 8'hFF, 0, 8'h00, 0);
    a_cyc(1, 0, 8'h04, 0, 8'h00, 0);
    a_cyc(1, 1, 8'h00, 0, 8'h00, 0);
    chk("A.cal07", {24'b0, a_cal}, 8'h07);
    a_cyc(1, 0, 8'h00, 1, 8'h07, 0);
    chk("A.match_done", {31'b0, a_done}, 1);
    chk("A.match_err", {31'b0, a_err}, 0);
    a_cyc(1, 0, 8'h00, 1, 8'h06, 0);
    chk("A.bits1", {28'b0, a_bits}, 1);
    a_cyc(1, 0, 8'h00, 1, 8'hF8, 0);
    chk("A.cnt1", {28'b0, a_cnt}, 1);
    chk("A.bits8", {28'b0, a_bits}, 8);
    a_cyc(0, 0, 8'h00, 0, 8'h00, 0);
    chk("A.cnt9", {28'b0, a_cnt}, BLK ? 2 : 9);
    a_cyc(0, 0, 8'h00, 0, 8'h00, 1);
    chk("A.clr", {28'b0, a_cnt}, 0);

    // saturation with CNT_W=4
    a_cyc(1, 1, 8'h10, 0, 8'h00, 0);
    a_cyc(1, 0, 8'h00, 1, 8'hFF, 0);
    a_cyc(0, 0, 8'h00, 0, 8'h00, 0);
    chk("A.sat1", {28'b0, a_cnt}, BLK ? 1 : 8);
    a_cyc(1, 1, 8'h00, 0, 8'h00, 0);
    chk("A.cal10", {24'b0, a_cal}, 8'h10);
    a_cyc(1, 0, 8'h00, 1, 8'hEF, 0);
    a_cyc(0, 0, 8'h00, 0, 8'h00, 0);
    chk("A.sat2", {28'b0, a_cnt}, BLK ? 2 : 15);
    a_cyc(1, 1, 8'h00, 0, 8'h00, 0);
    a_cyc(1, 0, 8'h00, 1, 8'hFF, 0);
    a_cyc(0, 0, 8'h00, 0, 8'h00, 0);
    chk("A.sat3", {28'b0, a_cnt}, BLK ? 3 : 15);
    a_cyc(1, 0, 8'h00, 1, 8'hFF, 0);
    a_cyc(0, 0, 8'h00, 0, 8'h00, 1);
    chk("A.clr_vs_inc", {28'b0, a_cnt}, 0);

    // reset mid-frame
    a_cyc(1, 0, 8'h5A, 0, 8'h00, 0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("A.rst_cal", {24'b0, a_cal}, 0);
    chk("A.rst_calv", {31'b0, a_calv}, 0);
    chk("A.rst_cnt", {28'b0, a_cnt}, 0);
    chk("A.rst_alarm", {31'b0, a_alarm}, 0);
    rst = 1'b0;

    // first frame discarded, then window of 4 reloads with 3 single-bit errors
    a_frame(8'h11, 8'h22, 1, 8'h00);
    chk("A.acq_no_done", {31'b0, a_done}, 0);
    a_frame(8'h01, 8'h00, 1, 8'h33);
    chk("A.resume_cal", {24'b0, a_cal}, 8'h33);
    chk("A.resume_done", {31'b0, a_done}, 1);
    a_frame(8'h00, 8'h00, 1, 8'h00);
    a_frame(8'h00, 8'h00, 1, 8'h80);
    a_frame(8'h00, 8'h00, 1, 8'h02);
    chk("A.alarm_pre", {31'b0, a_alarm}, 0);
    a_frame(8'h00, 8'h00, 0, 8'h00);
    chk("A.alarm_set", {31'b0, a_alarm}, 1);
    chk("A.win_cnt", {28'b0, a_cnt}, 3);
    for (int i = 0; i < 3; i++) a_frame(8'h00, 8'h00, 1, 8'h00);
    chk("A.alarm_hold", {31'b0, a_alarm}, 1);
    a_frame(8'h00, 8'h00, 1, 8'h00);
    chk("A.alarm_clear", {31'b0, a_alarm}, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
